password_vault: RTL and testbench

Parametrised successor to the team's 4x4-bit password store. Holds a DEPTH-digit password of DIGIT_W-bit digits and accepts digits serially in two modes:
- SET: stages the digits, then commits them atomically.
- VERIFY: compares each digit on the fly.

It counts consecutive failed verifies and enforces a timed lockout. It sits between the keypad/serial digit decoder and the lock actuator/status display.

---
 rtl/password_pkg.sv | 18 +
 rtl/password_vault_lockout_timer.sv | 34 +++
 rtl/password_vault.sv | 163 ++++++++++++++++
 tb/tb_password_vault.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/password_pkg.sv
// Shared types for the password vault.
//   state_e : session FSM states
//   mode_e  : session mode selected with start (mode input)
package password_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ENTER,
    RESULT,
    LOCKOUT
  } state_e;

  typedef enum logic {
    MODE_VERIFY = 1'b0,
    MODE_SET    = 1'b1
  } mode_e;

endpackage

// File: rtl/password_vault_lockout_timer.sv
// lockout_timer: down-counter that holds the vault in lockout.
//   CLK, RST : clock, asynchronous active-high reset
//   load     : (re)start the lockout period
//   en       : count down one step (while in lockout)
//   expired  : high in the final cycle of the period
// Loading LOCK_CYCLES-1 and expiring at zero gives exactly LOCK_CYCLES
// cycles between the load edge and the exit edge.
module lockout_timer #(
  parameter int unsigned LOCK_CYCLES = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(LOCK_CYCLES - 1);
    end else if (en && count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/password_vault.sv
// password_vault: DEPTH-digit password store with serial SET / VERIFY
// sessions, consecutive-failure counting and a timed lockout.
//   CLK, RST    : clock, asynchronous active-high reset
//   start, mode : begin a session in IDLE (mode 1=SET, 0=VERIFY)
//   digitValid, digitIn : serial digit entry
//   cancel      : abort the session in progress
//   busy, done, match, locked : status; match valid while done=1
//   failCount   : consecutive failed verifies
//   digitIndex  : digits accepted so far this session
// Optional build macro: SET_REQUIRES_AUTH_EN -- SET sessions are refused
// (done with match=0) unless the previous VERIFY passed.
module password_vault
  import password_pkg::*;
#(
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MAX_FAILS   = 3,
  parameter int unsigned LOCK_CYCLES = 8
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           start,
  input  logic                           mode,
  input  logic                           digitValid,
  input  logic [DIGIT_W-1:0]             digitIn,
  input  logic                           cancel,
  output logic                           busy,
  output logic                           done,
  output logic                           match,
  output logic                           locked,
  output logic [$clog2(MAX_FAILS+1)-1:0] failCount,
  output logic [$clog2(DEPTH+1)-1:0]     digitIndex
);

  localparam int unsigned FW = $clog2(MAX_FAILS + 1);
  localparam int unsigned IW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e             state, state_n;
  mode_e              mode_q;
  logic               mismatch;
  logic [DIGIT_W-1:0] stored [DEPTH];
  logic [DIGIT_W-1:0] shadow [DEPTH];
  logic [AW-1:0]      idx;
  logic               last;
  logic               set_denied;
  logic [FW-1:0]      fail_n;
  logic               timer_load;
  logic               timer_expired;

  assign idx  = digitIndex[AW-1:0];
  assign last = (digitIndex == IW'(DEPTH - 1));

`ifdef SET_REQUIRES_AUTH_EN
  logic auth;
  assign set_denied = (mode_e'(mode) == MODE_SET) && !auth;
`else
  assign set_denied = 1'b0;
`endif

  // failCount as it will be after the RESULT cycle; SET leaves it alone.
  always_comb begin
    fail_n = failCount;
    if (mode_q == MODE_VERIFY) begin
      if (!mismatch)
        fail_n = '0;
      else if (failCount != FW'(MAX_FAILS))
        fail_n = failCount + FW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = set_denied ? RESULT : ENTER;
      ENTER: begin
        if (cancel)                  state_n = IDLE;
        else if (digitValid && last) state_n = RESULT;
      end
      RESULT:  state_n = (fail_n == FW'(MAX_FAILS)) ? LOCKOUT : IDLE;
      LOCKOUT: if (timer_expired) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A refused SET is flagged through mismatch so that match=0 and the
  // commit in RESULT is suppressed without a separate result register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q     <= MODE_VERIFY;
      mismatch   <= 1'b0;
      digitIndex <= '0;
      failCount  <= '0;
      stored     <= '{default: '0};
      shadow     <= '{default: '0};
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q     <= mode_e'(mode);
            digitIndex <= '0;
            mismatch   <= set_denied;
          end
        end
        ENTER: begin
          if (cancel) begin
            digitIndex <= '0;
          end else if (digitValid) begin
            if (mode_q == MODE_SET)
              shadow[idx] <= digitIn;
            else if (digitIn != stored[idx])
              mismatch <= 1'b1;
            digitIndex <= last ? '0 : digitIndex + IW'(1);
          end
        end
        RESULT: begin
          failCount <= fail_n;
          if (mode_q == MODE_SET && !mismatch)
            stored <= shadow;
        end
        LOCKOUT: begin
          if (timer_expired) failCount <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef SET_REQUIRES_AUTH_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      auth <= 1'b0;
    end else if (state == ENTER && cancel) begin
      auth <= 1'b0;
    end else if (state == RESULT) begin
      auth <= (mode_q == MODE_VERIFY) && !mismatch;
    end
  end
`endif

  assign timer_load = (state == RESULT) && (state_n == LOCKOUT);

  lockout_timer #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .load    (timer_load),
    .en      (state == LOCKOUT),
    .expired (timer_expired)
  );

  assign busy   = (state != IDLE);
  assign done   = (state == RESULT);
  assign match  = (state == RESULT) && !mismatch;
  assign locked = (state == LOCKOUT);

endmodule

// File: tb/tb_password_vault.sv
module tb_password_vault;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned DEPTH       = 4;
  localparam int unsigned MAX_FAILS   = 3;
  localparam int unsigned LOCK_CYCLES = 8;
  localparam int unsigned FW = $clog2(MAX_FAILS + 1);
  localparam int unsigned IW = $clog2(DEPTH + 1);

  typedef logic [DIGIT_W-1:0] pw_t [DEPTH];

  logic               CLK = 1'b0;
  logic               RST = 1'b0;
  logic               start = 1'b0;
  logic               mode = 1'b0;
  logic               digitValid = 1'b0;
  logic [DIGIT_W-1:0] digitIn = '0;
  logic               cancel = 1'b0;
  logic               busy, done, match, locked;
  logic [FW-1:0]      failCount;
  logic [IW-1:0]      digitIndex;

  int checks = 0;
  int errors = 0;

  // Reference model: what the vault should remember between sessions.
  pw_t m_stored;
  int  m_fails;
  bit  m_auth;

  password_vault #(
    .DIGIT_W    (DIGIT_W),
    .DEPTH      (DEPTH),
    .MAX_FAILS  (MAX_FAILS),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .mode      (mode),
    .digitValid(digitValid),
    .digitIn   (digitIn),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .match     (match),
    .locked    (locked),
    .failCount (failCount),
    .digitIndex(digitIndex)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic pw_t mk(input int a, input int b, input int c, input int d);
    pw_t p;
    p[0] = DIGIT_W'(a); p[1] = DIGIT_W'(b); p[2] = DIGIT_W'(c); p[3] = DIGIT_W'(d);
    return p;
  endfunction

  function automatic bit same(input pw_t a, input pw_t b);
    for (int i = 0; i < DEPTH; i++) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  // One full session from start to return to IDLE (or through lockout).
  // cancel_at >= 0 asserts cancel together with that digit.
  task automatic do_session(input string nm, input bit m, input pw_t d,
                            input int cancel_at, input int maxgap);
    bit denied, exp_match;
    int n;
    denied = 1'b0;
`ifdef SET_REQUIRES_AUTH_EN
    denied = m && !m_auth;
`endif
    start = 1'b1; mode = m;
    tick();
    start = 1'b0; mode = 1'b0;
    if (denied) begin
      checks++;
      if (done !== 1'b1 || match !== 1'b0) begin
        errors++; $display("FAIL %s denied: done=%b match=%b want 1/0", nm, done, match);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || failCount !== FW'(m_fails)) begin
        errors++; $display("FAIL %s denied_after: done=%b busy=%b fc=%0d want 0/0/%0d",
                           nm, done, busy, failCount, m_fails);
      end
      return;
    end
    checks++;
    if (busy !== 1'b1 || digitIndex !== '0 || done !== 1'b0) begin
      errors++; $display("FAIL %s enter: busy=%b idx=%0d done=%b want 1/0/0", nm, busy, digitIndex, done);
    end
    exp_match = m ? 1'b1 : same(d, m_stored);
    for (int i = 0; i < DEPTH; i++) begin
      n = $urandom_range(maxgap, 0);
      for (int g = 0; g < n; g++) begin
        digitValid = 1'b0; digitIn = DIGIT_W'($urandom);
        tick();
      end
      if (n > 0) begin
        checks++;
        if (digitIndex !== IW'(i) || done !== 1'b0) begin
          errors++; $display("FAIL %s gap: idx=%0d done=%b want %0d/0", nm, digitIndex, done, i);
        end
      end
      digitValid = 1'b1; digitIn = d[i];
      if (i == cancel_at) begin
        cancel = 1'b1;
        tick();
        cancel = 1'b0; digitValid = 1'b0;
        m_auth = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || digitIndex !== '0) begin
          errors++; $display("FAIL %s cancel: busy=%b done=%b idx=%0d want 0/0/0", nm, busy, done, digitIndex);
        end
        tick();
        checks++;
        if (done !== 1'b0 || failCount !== FW'(m_fails)) begin
          errors++; $display("FAIL %s cancel_after: done=%b fc=%0d want 0/%0d", nm, done, failCount, m_fails);
        end
        return;
      end
      tick();
      digitValid = 1'b0;
      if (i < DEPTH - 1) begin
        checks++;
        if (digitIndex !== IW'(i + 1) || done !== 1'b0) begin
          errors++; $display("FAIL %s idx: got=%0d done=%b want %0d/0", nm, digitIndex, done, i + 1);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || match !== exp_match || digitIndex !== '0) begin
      errors++; $display("FAIL %s result: done=%b match=%b idx=%0d want 1/%b/0",
                         nm, done, match, digitIndex, exp_match);
    end
    if (m) begin
      m_stored = d; m_auth = 1'b0;
    end else if (exp_match) begin
      m_fails = 0; m_auth = 1'b1;
    end else begin
      if (m_fails < MAX_FAILS) m_fails++;
      m_auth = 1'b0;
    end
    tick();
    checks++;
    if (done !== 1'b0 || match !== 1'b0 || failCount !== FW'(m_fails) ||
        locked !== (m_fails == MAX_FAILS)) begin
      errors++; $display("FAIL %s post: done=%b match=%b fc=%0d locked=%b want 0/0/%0d/%b",
                         nm, done, match, failCount, locked, m_fails, m_fails == MAX_FAILS);
    end
    if (m_fails == MAX_FAILS) begin
      n = 1;
      for (int k = 0; k < LOCK_CYCLES + 4; k++) begin
        start = (k == 2); mode = 1'b0; digitValid = (k == 3); cancel = (k == 4);
        tick();
        if (!locked) break;
        n++;
      end
      start = 1'b0; digitValid = 1'b0; cancel = 1'b0;
      m_fails = 0;
      checks++;
      if (n != LOCK_CYCLES || failCount !== '0 || busy !== 1'b0) begin
        errors++; $display("FAIL %s lockout: cycles=%0d fc=%0d busy=%b want %0d/0/0",
                           nm, n, failCount, busy, LOCK_CYCLES);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || match !== 1'b0 || locked !== 1'b0 ||
        failCount !== '0 || digitIndex !== '0) begin
      errors++; $display("FAIL reset: busy=%b done=%b match=%b locked=%b fc=%0d idx=%0d want all 0",
                         busy, done, match, locked, failCount, digitIndex);
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    m_stored = mk(0, 0, 0, 0); m_fails = 0; m_auth = 1'b0;
  endtask

  task automatic test_verify_default();
    do_session("verify_zero", 1'b0, mk(0, 0, 0, 0), -1, 0);
  endtask

  task automatic test_set_verify();
    do_session("set_1234", 1'b1, mk(1, 2, 3, 4), -1, 0);
    do_session("verify_1234", 1'b0, mk(1, 2, 3, 4), -1, 0);
    do_session("verify_1235", 1'b0, mk(1, 2, 3, 5), -1, 0);
  endtask

  task automatic test_cancel();
    do_session("auth_pass", 1'b0, mk(1, 2, 3, 4), -1, 0);
    do_session("set_cancel2", 1'b1, mk(9, 9, 9, 9), 2, 0);
    do_session("verify_keep", 1'b0, mk(1, 2, 3, 4), -1, 0);
    do_session("set_cancel_last", 1'b1, mk(5, 5, 5, 5), DEPTH - 1, 1);
    do_session("verify_keep2", 1'b0, mk(1, 2, 3, 4), -1, 0);
  endtask

  task automatic test_lockout();
    do_session("wrong1", 1'b0, mk(4, 3, 2, 1), -1, 0);
    do_session("wrong2", 1'b0, mk(0, 2, 3, 4), -1, 0);
    do_session("wrong3", 1'b0, mk(1, 2, 3, 15), -1, 0);
  endtask

  task automatic test_gaps();
    do_session("gap_wrong", 1'b0, mk(1, 2, 4, 4), -1, 3);
    do_session("gap_right", 1'b0, mk(1, 2, 3, 4), -1, 3);
  endtask

`ifdef SET_REQUIRES_AUTH_EN
  task automatic test_auth();
    do_session("auth_fail", 1'b0, mk(8, 8, 8, 8), -1, 0);
    do_session("set_denied", 1'b1, mk(7, 7, 7, 7), -1, 0);
    do_session("verify_unchanged", 1'b0, mk(1, 2, 3, 4), -1, 0);
    do_session("set_allowed", 1'b1, mk(7, 7, 7, 7), -1, 0);
    do_session("verify_7777", 1'b0, mk(7, 7, 7, 7), -1, 0);
  endtask
`endif

  task automatic test_random();
    pw_t d;
    bit  m;
    int  c;
    for (int s = 0; s < 30; s++) begin
      m = ($urandom_range(3, 0) == 0);
      d = m_stored;
      if (m || $urandom_range(1, 0) == 1) begin
        for (int i = 0; i < DEPTH; i++) d[i] = DIGIT_W'($urandom);
      end
      c = ($urandom_range(5, 0) == 0) ? int'($urandom_range(DEPTH - 1, 0)) : -1;
      do_session("random", m, d, c, 3);
    end
  endtask

  task automatic test_back_to_back();
    do_session("b2b_pass", 1'b0, m_stored, -1, 0);
    do_session("b2b_set", 1'b1, mk(3, 1, 4, 1), -1, 0);
    do_session("b2b_verify", 1'b0, mk(3, 1, 4, 1), -1, 0);
  endtask

  initial begin
    test_reset();
    test_verify_default();
    test_set_verify();
    test_cancel();
    test_lockout();
    test_gaps();
`ifdef SET_REQUIRES_AUTH_EN
    test_auth();
`endif
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
